// File: rtl/ss_mac_scheduler_pkg.sv
// Shared types, constants and helpers for the stochastic-symbol MAC scheduler.
// Lane count, widths, LFSR seeds/taps and the job-length wrap threshold live here.
package ss_mac_pkg;

  localparam int LANES  = 8;
  localparam int SEL_W  = $clog2(LANES);
  localparam int ACC_W  = 11;
  localparam int RND_W  = 8;
  localparam int PASS_W = 8;
  localparam int CNT_W  = 11;

  // 66 adds of at most 31 each stay below 2^ACC_W; longer jobs may alias.
  localparam logic [CNT_W-1:0] WRAP_LIMIT = CNT_W'(66);
  localparam logic [RND_W-1:0] LFSR_TAPS  = 8'hB8;
  localparam logic [RND_W-1:0] SEED [LANES] = '{
    8'h5A, 8'hC3, 8'h1F, 8'hE4, 8'h96, 8'h2B, 8'h71, 8'hB8
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    state_t state;
    logic   lane_wrap;
  } dbg_t;

  function automatic logic [SEL_W-1:0] lowest_lane(input logic [LANES-1:0] mask);
    lowest_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) lowest_lane = SEL_W'(i);
    end
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] mask);
    popcount = '0;
    for (int i = 0; i < LANES; i++) begin
      popcount = popcount + CNT_W'(mask[i]);
    end
  endfunction

  // Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [RND_W-1:0] lfsr_step(input logic [RND_W-1:0] s);
    lfsr_step = {s[RND_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ss_mac_scheduler_if.sv
// Job-control and MAC-side signals of the scheduler, bundled with host/DUT modports.
// start is a request sampled only in IDLE (abort in the same cycle suppresses it); done is a 1-cycle strobe.
interface ss_mac_scheduler_if;
  import ss_mac_pkg::*;

  logic                   start;
  logic                   abort;
  logic [LANES-1:0]       cfg_lane_mask;
  logic [PASS_W-1:0]      cfg_passes;
  logic                   busy;
  logic                   done;
  logic [ACC_W-1:0]       result;
  logic                   result_wrap;
  logic                   cfg_err;
  logic [SEL_W-1:0]       mac_sel;
  logic [LANES*RND_W-1:0] mac_randnum;
  logic [ACC_W-1:0]       mac_z;
  dbg_t                   dbg;

  modport master (
    output start, abort, cfg_lane_mask, cfg_passes, mac_z,
    input  busy, done, result, result_wrap, cfg_err, mac_sel, mac_randnum, dbg
  );

  modport slave (
    input  start, abort, cfg_lane_mask, cfg_passes, mac_z,
    output busy, done, result, result_wrap, cfg_err, mac_sel, mac_randnum, dbg
  );

endinterface

// File: rtl/ss_mac_scheduler_lane_next.sv
// Combinational round-robin step: next set lane above the current one, wrapping to the lowest.
// o_wrapped marks the wrap; pass counting is done by the job-cycle counter, not by this flag.
module ss_lane_next
  import ss_mac_pkg::*;
(
  input  logic [LANES-1:0] i_mask,
  input  logic [SEL_W-1:0] i_cur,
  output logic [SEL_W-1:0] o_next,
  output logic             o_wrapped
);

  always_comb begin
    o_next    = lowest_lane(i_mask);
    o_wrapped = 1'b1;
    // Descending scan so the lowest qualifying lane above i_cur is the last one written.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (i > int'(i_cur) && i_mask[i]) begin
        o_next    = SEL_W'(i);
        o_wrapped = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ss_mac_scheduler.sv
// Job sequencer for the 8-lane SS MAC: steps the lane select, drives per-lane LFSRs and
// reports the accumulator delta over the job as the result.
module ss_mac_scheduler
  import ss_mac_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  ss_mac_scheduler_if.slave   bus
);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [ACC_W-1:0] r_result;
  logic             r_result_wrap;
  logic             r_cfg_err;
  logic [SEL_W-1:0] r_sel;
  logic [ACC_W-1:0] r_base;
  logic [LANES-1:0] r_mask;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  logic             r_wrap_pend;
  logic [RND_W-1:0] r_lfsr [LANES];

  logic [SEL_W-1:0]       w_next_sel;
  logic                   w_lane_wrap;
  logic [CNT_W-1:0]       w_job_len;
  logic                   w_cfg_zero;
  logic                   w_req;
  logic                   w_accept;
  logic [LANES*RND_W-1:0] w_randnum;

  ss_lane_next u_lane_next (
    .i_mask    (r_mask),
    .i_cur     (r_sel),
    .o_next    (w_next_sel),
    .o_wrapped (w_lane_wrap)
  );

  assign w_job_len  = popcount(bus.cfg_lane_mask) * CNT_W'(bus.cfg_passes);
  assign w_cfg_zero = (bus.cfg_lane_mask == '0) || (bus.cfg_passes == '0);
  assign w_req      = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_accept   = w_req && !w_cfg_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_result_wrap <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_sel         <= '0;
      r_base        <= '0;
      r_mask        <= '0;
      r_cnt         <= '0;
      r_first       <= 1'b0;
      r_wrap_pend   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req && w_cfg_zero) begin
            r_done        <= 1'b1;
            r_cfg_err     <= 1'b1;
            r_result      <= '0;
            r_result_wrap <= 1'b0;
          end else if (w_accept) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_mask      <= bus.cfg_lane_mask;
            r_sel       <= lowest_lane(bus.cfg_lane_mask);
            r_cnt       <= w_job_len;
            r_first     <= 1'b1;
            r_wrap_pend <= (w_job_len > WRAP_LIMIT);
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            // The edge ending RUN cycle 1 is excluded; the DRAIN entry edge makes up the count.
            if (r_first) r_base <= bus.mac_z;
            r_first <= 1'b0;
            r_sel   <= w_next_sel;
            r_cnt   <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!bus.abort) begin
            r_result      <= bus.mac_z - r_base;
            r_result_wrap <= r_wrap_pend;
            r_cfg_err     <= 1'b0;
            r_done        <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lfsr
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_lfsr[g] <= SEED[g];
      end else if (w_accept) begin
        r_lfsr[g] <= SEED[g];
      end else if (r_state == S_RUN) begin
        r_lfsr[g] <= lfsr_step(r_lfsr[g]);
      end
    end
  end

  always_comb begin
    w_randnum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_randnum[i*RND_W +: RND_W] = r_lfsr[i];
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.result        = r_result;
  assign bus.result_wrap   = r_result_wrap;
  assign bus.cfg_err       = r_cfg_err;
  assign bus.mac_sel       = r_sel;
  assign bus.mac_randnum   = w_randnum;
  assign bus.dbg.state     = r_state;
  assign bus.dbg.lane_wrap = w_lane_wrap;

endmodule
